// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus between fetch_stage and its memory.
// master: drives imem_addr/imem_req; slave: returns imem_ack/imem_data.
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_data;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_ack,
      output imem_data
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over imem, holds the word
// for decode, mirrors PC updates to registerbank (pc_write/pc_w).
// Ports: clk, rst, imem (master), branch_valid/branch_target, stall,
// instr/instr_valid, address1/address2 (Rn/Rm), pc_write/pc_w.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                 clk,
   input  logic                 rst,
   fetch_stage_if.master        imem,
   input  logic                 branch_valid,
   input  logic [31:0]          branch_target,
   input  logic                 stall,
   output logic [31:0]          instr,
   output logic                 instr_valid,
   output logic [4:0]           address1,
   output logic [4:0]           address2,
   output logic [31:0]          pc_write,
   output logic                 pc_w
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DRAIN,
      VALID
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_write_q, pc_write_d;
   logic        pc_w_q, pc_w_d;

   logic [31:0] tgt;
   logic [31:0] seq_pc;
   logic        take_br;

   assign tgt     = branch_target & ~32'h3;
   assign seq_pc  = addr_q + PC_STEP;
   assign take_br = branch_valid && (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      req_d      = req_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      pc_write_d = pc_write_q;
      pc_w_d     = 1'b0;

      if (take_br) begin
         // Redirect wins over ack and stall.
         pc_d       = tgt;
         pc_write_d = tgt;
         pc_w_d     = 1'b1;
         valid_d    = 1'b0;
         req_d      = 1'b1;
         // An unacked fetch must still complete: squash it in DRAIN,
         // keeping its address on the bus.
         if ((state_q == REQ || state_q == DRAIN) && !imem.imem_ack) begin
            state_d = DRAIN;
         end else begin
            state_d = REQ;
            addr_d  = tgt;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = REQ;
               addr_d  = pc_q;
               req_d   = 1'b1;
            end
            REQ: begin
               if (imem.imem_ack) begin
                  instr_d    = imem.imem_data;
                  valid_d    = 1'b1;
                  pc_d       = seq_pc;
                  pc_write_d = seq_pc;
                  pc_w_d     = 1'b1;
                  req_d      = 1'b0;
                  state_d    = VALID;
               end
            end
            DRAIN: begin
               if (imem.imem_ack) begin
                  state_d = REQ;
                  addr_d  = pc_q;
               end
            end
            VALID: begin
               if (!stall) begin
                  valid_d = 1'b0;
                  req_d   = 1'b1;
                  addr_d  = pc_q;
                  state_d = REQ;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= '0;
         req_q      <= 1'b0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         pc_write_q <= '0;
         pc_w_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         pc_write_q <= pc_write_d;
         pc_w_q     <= pc_w_d;
      end
   end

   assign imem.imem_addr = addr_q;
   assign imem.imem_req  = req_q;
   assign instr          = instr_q;
   assign instr_valid    = valid_q;
   assign address1       = {1'b0, instr_q[19:16]};
   assign address2       = {1'b0, instr_q[3:0]};
   assign pc_write       = pc_write_q;
   assign pc_w           = pc_w_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// checked against a transaction-level model of the fetch rules.
module tb_fetch_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        stall;
   logic [31:0] instr;
   logic        instr_valid;
   logic [4:0]  address1, address2;
   logic [31:0] pc_write;
   logic        pc_w;

   logic [31:0] w_instr;
   logic        w_instr_valid;
   logic [4:0]  w_address1, w_address2;
   logic [31:0] w_pc_write;
   logic        w_pc_w;

   fetch_stage_if u_if ();
   fetch_stage_if w_if ();

   fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (u_if),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .stall         (stall),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .address1      (address1),
      .address2      (address2),
      .pc_write      (pc_write),
      .pc_w          (pc_w)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_dut_w (
      .clk           (clk),
      .rst           (rst),
      .imem          (w_if),
      .branch_valid  (1'b0),
      .branch_target (32'h0),
      .stall         (1'b0),
      .instr         (w_instr),
      .instr_valid   (w_instr_valid),
      .address1      (w_address1),
      .address2      (w_address2),
      .pc_write      (w_pc_write),
      .pc_w          (w_pc_w)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: is a fetch outstanding, is it squashed, what is held for decode.
   bit          m_started, m_req, m_squash, m_valid, m_pcw;
   logic [31:0] m_pc, m_addr, m_instr, m_pcwrite;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_req = 0; m_squash = 0; m_valid = 0; m_pcw = 0;
      m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_pcwrite = 32'h0;
   endtask

   task automatic model_edge(input logic br, input logic [31:0] tgt,
                             input logic ak, input logic [31:0] dat,
                             input logic st);
      logic [31:0] t;
      t = {tgt[31:2], 2'b00};
      m_pcw = 0;
      if (!m_started) begin
         m_started = 1; m_req = 1; m_squash = 0; m_addr = m_pc;
      end else if (br) begin
         m_pc = t; m_pcw = 1; m_pcwrite = t; m_valid = 0;
         if (m_req && !ak) m_squash = 1;
         else begin m_req = 1; m_squash = 0; m_addr = t; end
      end else if (m_req && ak) begin
         if (m_squash) begin
            m_squash = 0; m_addr = m_pc;
         end else begin
            m_instr = dat; m_valid = 1; m_pc = m_addr + 32'd4;
            m_pcw = 1; m_pcwrite = m_pc; m_req = 0;
         end
      end else if (!m_req && !st) begin
         m_valid = 0; m_req = 1; m_addr = m_pc;
      end
   endtask

   task automatic check_all();
      chk("imem_req",    32'(u_if.imem_req), 32'(m_req));
      chk("imem_addr",   u_if.imem_addr, m_addr);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr",       instr, m_instr);
      chk("address1",    32'(address1), 32'(m_instr[19:16]));
      chk("address2",    32'(address2), 32'(m_instr[3:0]));
      chk("pc_w",        32'(pc_w), 32'(m_pcw));
      chk("pc_write",    pc_write, m_pcwrite);
   endtask

   task automatic cyc(input logic br, input logic [31:0] tgt,
                      input logic ak, input logic [31:0] dat,
                      input logic st);
      branch_valid  = br;
      branch_target = tgt;
      u_if.imem_ack  = ak;
      u_if.imem_data = dat;
      stall         = st;
      @(posedge clk);
      model_edge(br, tgt, ak, dat, st);
      #1;
      check_all();
   endtask

   initial begin
      logic        br, ak, st;
      logic [31:0] tgt, dat;

      rst = 1'b1;
      branch_valid = 0; branch_target = 0; stall = 0;
      u_if.imem_ack = 0; u_if.imem_data = 0;
      w_if.imem_ack = 0; w_if.imem_data = 0;
      model_reset();
      @(posedge clk); #1;
      check_all();
      chk("w_reset_req",  32'(w_if.imem_req), 32'h0);
      chk("w_reset_addr", w_if.imem_addr, 32'h0);
      rst = 1'b0;

      // First fetch from reset, zero-wait ack.
      cyc(0, 0, 0, 0, 0);
      chk("t1_req",  32'(u_if.imem_req), 32'h1);
      chk("t1_addr", u_if.imem_addr, 32'h0);
      cyc(0, 0, 1, 32'hE081_2003, 1);
      chk("t1_instr",    instr, 32'hE081_2003);
      chk("t1_address1", 32'(address1), 32'h01);
      chk("t1_address2", 32'(address2), 32'h03);
      chk("t1_pc_write", pc_write, 32'h4);
      chk("t1_pc_w",     32'(pc_w), 32'h1);

      // Stall while VALID.
      repeat (5) cyc(0, 0, 0, 0, 1);
      chk("t2_valid_held", 32'(instr_valid), 32'h1);
      chk("t2_req_low",    32'(u_if.imem_req), 32'h0);
      cyc(0, 0, 0, 0, 0);
      chk("t2_next_addr", u_if.imem_addr, 32'h4);

      // Branch while waiting on ack; stale data drained.
      cyc(1, 32'h0000_0103, 0, 0, 0);
      chk("t3_pc_write", pc_write, 32'h100);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'hDEAD_BEEF, 0);
      chk("t3_addr",  u_if.imem_addr, 32'h100);
      chk("t3_valid", 32'(instr_valid), 32'h0);

      // Branch and ack in the same cycle.
      cyc(1, 32'h0000_2001, 1, 32'hBADB_AD00, 0);
      chk("t4_addr", u_if.imem_addr, 32'h2000);
      cyc(0, 0, 1, 32'h1111_1111, 0);
      cyc(0, 0, 0, 0, 0);

      // Reset mid-fetch, stale ack while IDLE.
      cyc(0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(0, 0, 1, 32'h5555_AAAA, 0);
      chk("t6_addr", u_if.imem_addr, 32'h0);
      chk("t6_req",  32'(u_if.imem_req), 32'h1);
      chk("w_addr0", w_if.imem_addr, 32'hFFFF_FFFC);

      // PC wrap on the second instance.
      w_if.imem_ack  = 1;
      w_if.imem_data = 32'h1234_5678;
      cyc(0, 0, 0, 0, 0);
      w_if.imem_ack = 0;
      chk("w_pc_w",     32'(w_pc_w), 32'h1);
      chk("w_pc_write", w_pc_write, 32'h0);
      chk("w_instr",    w_instr, 32'h1234_5678);
      cyc(0, 0, 0, 0, 0);
      chk("w_next_addr", w_if.imem_addr, 32'h0);
      chk("w_next_req",  32'(w_if.imem_req), 32'h1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         br  = ($urandom_range(0, 7) == 0);
         tgt = $urandom;
         ak  = m_req && ($urandom_range(0, 2) == 0);
         dat = $urandom;
         st  = ($urandom_range(0, 1) == 0);
         cyc(br, tgt, ak, dat, st);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
